// File: rtl/segre_mem_stage.sv
// Memory stage: drives the data-memory req/ready handshake for loads and stores,
// aligns/extends load data and registers the writeback bundle for the WB stage.
// WORD_SIZE/REG_SIZE/HF_PTR default to the segre core widths; the lane logic assumes
// WORD_SIZE = 32.
module segre_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned REG_SIZE       = 5,
    parameter int unsigned HF_PTR         = 4
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic [WORD_SIZE-1:0] alu_res_i,
    input  logic                 rf_we_i,
    input  logic [REG_SIZE-1:0]  rf_waddr_i,
    input  logic                 tkbr_i,
    input  logic [WORD_SIZE-1:0] new_pc_i,
    input  logic                 branch_completed_i,
    input  logic [HF_PTR-1:0]    instr_id_i,
    input  logic                 memop_rd_i,
    input  logic                 memop_wr_i,
    input  logic [1:0]           memop_size_i,
    input  logic                 memop_sext_i,
    input  logic [WORD_SIZE-1:0] store_data_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [WORD_SIZE-1:0] mem_addr_o,
    output logic [3:0]           mem_be_o,
    output logic [WORD_SIZE-1:0] mem_wdata_o,
    input  logic                 mem_ready_i,
    input  logic [WORD_SIZE-1:0] mem_rdata_i,
    output logic                 hazard_o,
    output logic [WORD_SIZE-1:0] rf_wdata_o,
    output logic                 rf_we_o,
    output logic [REG_SIZE-1:0]  rf_waddr_o,
    output logic                 tkbr_o,
    output logic [WORD_SIZE-1:0] new_pc_o,
    output logic                 branch_completed_o,
    output logic [HF_PTR-1:0]    instr_id_o,
    output logic                 misaligned_o,
    output logic                 bus_err_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [1:0]           offset;
    logic                 is_memop, is_store, misaligned;
    logic                 complete, abort;
    logic [WORD_SIZE-1:0] rdata_shifted, load_data;

    assign offset     = alu_res_i[1:0];
    assign is_memop   = memop_rd_i | memop_wr_i;
    // A simultaneous read+write request is handled as a store.
    assign is_store   = memop_wr_i;
    assign mem_we_o   = memop_wr_i;
    assign mem_addr_o = {alu_res_i[WORD_SIZE-1:2], 2'b00};

    // Alignment check: halves need an even address, words (size 2 or 3) a multiple of 4.
    always_comb begin
        case (memop_size_i)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = offset[0];
            default: misaligned = (offset != 2'b00);
        endcase
    end

    // Handshake FSM next-state, request/stall generation and timeout counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_req_o = 1'b0;
        hazard_o  = 1'b0;
        complete  = 1'b0;
        abort     = 1'b0;
        case (state_q)
            StIdle: begin
                if (is_memop && !misaligned) begin
                    mem_req_o = 1'b1;
                    if (mem_ready_i) begin
                        complete = 1'b1;
                    end else begin
                        hazard_o = 1'b1;
                        state_d  = StWait;
                        cnt_d    = '0;
                    end
                end
            end
            StWait: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                    cnt_d    = '0;
                end else if (cnt_q == CntMax) begin
                    // Drop the stall on abort so the faulting instruction retires.
                    abort   = 1'b1;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    hazard_o = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Reset is synchronous, but the request must vanish in the cycle it is sampled.
        if (!rsn_i) begin
            mem_req_o = 1'b0;
            hazard_o  = 1'b0;
            complete  = 1'b0;
            abort     = 1'b0;
        end
    end

    // Store lane steering: enables follow the byte offset, data is replicated across lanes.
    always_comb begin
        case (memop_size_i)
            2'd0: begin
                mem_be_o    = 4'b0001 << offset;
                mem_wdata_o = {4{store_data_i[7:0]}};
            end
            2'd1: begin
                mem_be_o    = 4'b0011 << offset;
                mem_wdata_o = {2{store_data_i[15:0]}};
            end
            default: begin
                mem_be_o    = 4'b1111;
                mem_wdata_o = store_data_i;
            end
        endcase
    end

    // Load alignment: shift the addressed lane down, then truncate and extend.
    assign rdata_shifted = mem_rdata_i >> {offset, 3'b000};
    always_comb begin
        case (memop_size_i)
            2'd0:    load_data = {{(WORD_SIZE-8){memop_sext_i & rdata_shifted[7]}},
                                  rdata_shifted[7:0]};
            2'd1:    load_data = {{(WORD_SIZE-16){memop_sext_i & rdata_shifted[15]}},
                                  rdata_shifted[15:0]};
            default: load_data = rdata_shifted;
        endcase
    end

    // State, counter and WB bundle; the bundle only advances when not stalled.
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            state_q            <= StIdle;
            cnt_q              <= '0;
            rf_wdata_o         <= '0;
            rf_we_o            <= 1'b0;
            rf_waddr_o         <= '0;
            tkbr_o             <= 1'b0;
            new_pc_o           <= '0;
            branch_completed_o <= 1'b0;
            instr_id_o         <= '0;
            misaligned_o       <= 1'b0;
            bus_err_o          <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            misaligned_o <= (state_q == StIdle) & is_memop & misaligned;
            bus_err_o    <= abort;
            if (!hazard_o) begin
                rf_wdata_o         <= (complete && !is_store) ? load_data : alu_res_i;
                rf_we_o            <= rf_we_i & ~(is_memop & (is_store | misaligned | abort));
                rf_waddr_o         <= rf_waddr_i;
                tkbr_o             <= tkbr_i;
                new_pc_o           <= new_pc_i;
                branch_completed_o <= branch_completed_i;
                instr_id_o         <= instr_id_i;
            end
        end
    end

endmodule

// File: tb/tb_segre_mem_stage.sv
// Bench for segre_mem_stage: acts as EX stage and data memory, predicts every output
// from instruction-level rules and compares each negedge, plus directed literal cases.
module tb_segre_mem_stage;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        rsn_i;
    logic [31:0] alu_res_i, new_pc_i, store_data_i, mem_rdata_i;
    logic        rf_we_i, tkbr_i, branch_completed_i, memop_rd_i, memop_wr_i, memop_sext_i;
    logic [4:0]  rf_waddr_i;
    logic [3:0]  instr_id_i;
    logic [1:0]  memop_size_i;
    logic        mem_ready_i;
    logic        mem_req_o, mem_we_o, hazard_o, rf_we_o, tkbr_o, branch_completed_o;
    logic        misaligned_o, bus_err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, rf_wdata_o, new_pc_o;
    logic [3:0]  mem_be_o, instr_id_o;
    logic [4:0]  rf_waddr_o;

    segre_mem_stage dut (
        .clk_i(clk), .rsn_i(rsn_i), .alu_res_i(alu_res_i), .rf_we_i(rf_we_i),
        .rf_waddr_i(rf_waddr_i), .tkbr_i(tkbr_i), .new_pc_i(new_pc_i),
        .branch_completed_i(branch_completed_i), .instr_id_i(instr_id_i),
        .memop_rd_i(memop_rd_i), .memop_wr_i(memop_wr_i), .memop_size_i(memop_size_i),
        .memop_sext_i(memop_sext_i), .store_data_i(store_data_i), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .hazard_o(hazard_o), .rf_wdata_o(rf_wdata_o), .rf_we_o(rf_we_o),
        .rf_waddr_o(rf_waddr_o), .tkbr_o(tkbr_o), .new_pc_o(new_pc_o),
        .branch_completed_o(branch_completed_o), .instr_id_o(instr_id_o),
        .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic        we;
        logic [4:0]  waddr;
        logic        tkbr;
        logic [31:0] pc;
        logic        bc;
        logic [3:0]  id;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          lat;   // cycle index at which memory answers; > TO means never
    } instr_t;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    // Expected values consumed by the compare process.
    logic        exp_req, exp_haz, exp_we_mem, exp_store;
    logic [31:0] exp_addr, exp_wd;
    logic [3:0]  exp_be;
    logic [31:0] exp_rf_wdata, exp_pc;
    logic        exp_rf_we, exp_tkbr, exp_bc, exp_mis, exp_berr;
    logic [4:0]  exp_waddr;
    logic [3:0]  exp_id;

    int          haz_seen;
    logic [3:0]  first_be;
    logic [31:0] first_wd;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] load_value(input logic [31:0] rd, input int off,
                                               input int nb, input logic sx);
        logic [31:0] sh, mask, v;
        sh   = rd >> (8 * off);
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v    = sh & mask;
        if (sx && nb < 4 && sh[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    // Compare every output against the model once per cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("hazard_o", 32'(hazard_o), 32'(exp_haz));
            check("mem_req_o", 32'(mem_req_o), 32'(exp_req));
            if (exp_req) begin
                check("mem_we_o", 32'(mem_we_o), 32'(exp_we_mem));
                check("mem_addr_o", mem_addr_o, exp_addr);
                if (exp_store) begin
                    check("mem_be_o", 32'(mem_be_o), 32'(exp_be));
                    check("mem_wdata_o", mem_wdata_o, exp_wd);
                end
            end
            check("rf_wdata_o", rf_wdata_o, exp_rf_wdata);
            check("rf_we_o", 32'(rf_we_o), 32'(exp_rf_we));
            check("rf_waddr_o", 32'(rf_waddr_o), 32'(exp_waddr));
            check("tkbr_o", 32'(tkbr_o), 32'(exp_tkbr));
            check("new_pc_o", new_pc_o, exp_pc);
            check("branch_completed_o", 32'(branch_completed_o), 32'(exp_bc));
            check("instr_id_o", 32'(instr_id_o), 32'(exp_id));
            check("misaligned_o", 32'(misaligned_o), 32'(exp_mis));
            check("bus_err_o", 32'(bus_err_o), 32'(exp_berr));
        end
    end

    task automatic apply(input instr_t t);
        alu_res_i = t.alu; rf_we_i = t.we; rf_waddr_i = t.waddr; tkbr_i = t.tkbr;
        new_pc_i = t.pc; branch_completed_i = t.bc; instr_id_i = t.id;
        memop_rd_i = t.rd; memop_wr_i = t.wr; memop_size_i = t.size;
        memop_sext_i = t.sext; store_data_i = t.sd;
    endtask

    task automatic clear_bundle();
        exp_rf_wdata = '0; exp_rf_we = 1'b0; exp_waddr = '0; exp_tkbr = 1'b0;
        exp_pc = '0; exp_bc = 1'b0; exp_id = '0; exp_mis = 1'b0; exp_berr = 1'b0;
    endtask

    // Issue one instruction, play memory, and update the model when it retires.
    task automatic run_instr(input instr_t t);
        logic memop, mis, berr, is_load;
        int   off, nb;
        apply(t);
        memop   = t.rd | t.wr;
        off     = int'(t.alu[1:0]);
        nb      = nbytes(t.size);
        mis     = memop && ((off % nb) != 0);
        berr    = memop && !mis && (t.lat > TO);
        is_load = t.rd && !t.wr;
        haz_seen = 0;
        exp_req    = memop && !mis;
        exp_we_mem = t.wr;
        exp_addr   = {t.alu[31:2], 2'b00};
        exp_store  = t.wr;
        exp_be     = 4'(((1 << nb) - 1) << off);
        exp_wd     = (nb == 1) ? t.sd[7:0] * 32'h0101_0101 :
                     (nb == 2) ? t.sd[15:0] * 32'h0001_0001 : t.sd;
        for (int k = 0; k <= TO; k++) begin
            mem_ready_i = memop ? (k == t.lat) : 1'($urandom_range(0, 1));
            mem_rdata_i = (k == t.lat) ? t.rdata : $urandom;
            exp_haz = exp_req && (k < t.lat) && (k < TO);
            @(negedge clk);
            if (k == 0) begin
                first_be = mem_be_o;
                first_wd = mem_wdata_o;
            end
            if (hazard_o) haz_seen++;
            @(posedge clk);
            #1;
            if (!exp_haz) begin
                exp_rf_wdata = (is_load && !mis && !berr) ?
                               load_value(t.rdata, off, nb, t.sext) : t.alu;
                exp_rf_we = t.we && !(memop && (t.wr || mis || berr));
                exp_waddr = t.waddr; exp_tkbr = t.tkbr; exp_pc = t.pc;
                exp_bc = t.bc; exp_id = t.id; exp_mis = mis; exp_berr = berr;
                break;
            end
            exp_mis  = 1'b0;
            exp_berr = 1'b0;
        end
        mem_ready_i = 1'b0;
    endtask

    function automatic instr_t blank();
        instr_t t;
        t.alu = '0; t.we = 1'b0; t.waddr = '0; t.tkbr = 1'b0; t.pc = '0; t.bc = 1'b0;
        t.id = '0; t.rd = 1'b0; t.wr = 1'b0; t.size = 2'd2; t.sext = 1'b0; t.sd = '0;
        t.rdata = '0; t.lat = 0;
        return t;
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        int kind;
        logic [1:0] amask;
        t = blank();
        t.alu = $urandom; t.we = 1'($urandom); t.waddr = 5'($urandom);
        t.tkbr = 1'($urandom); t.pc = $urandom; t.bc = 1'($urandom); t.id = 4'($urandom);
        t.size = 2'($urandom); t.sext = 1'($urandom); t.sd = $urandom; t.rdata = $urandom;
        kind = $urandom_range(0, 9);
        t.rd = (kind >= 4 && kind <= 6) || kind == 9;
        t.wr = (kind >= 7);
        amask = (t.size == 2'd0) ? 2'b11 : (t.size == 2'd1) ? 2'b10 : 2'b00;
        if ($urandom_range(0, 3) != 0) t.alu[1:0] = t.alu[1:0] & amask;
        case ($urandom_range(0, 39))
            0:       t.lat = 1000;
            1:       t.lat = TO;
            2:       t.lat = TO - 1;
            default: t.lat = $urandom_range(0, 4);
        endcase
        return t;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        instr_t t;
        rsn_i = 1'b0;
        apply(blank());
        mem_ready_i = 1'b0; mem_rdata_i = '0;
        exp_req = 1'b0; exp_haz = 1'b0; exp_we_mem = 1'b0; exp_store = 1'b0;
        exp_addr = '0; exp_wd = '0; exp_be = '0;
        clear_bundle();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        rsn_i = 1'b1;

        // ALU pass-through.
        t = blank(); t.alu = 32'h1234; t.we = 1'b1; t.waddr = 5'd5;
        run_instr(t);
        check("alu_wdata_lit", rf_wdata_o, 32'h0000_1234);
        check("alu_we_lit", 32'(rf_we_o), 32'd1);
        check("alu_waddr_lit", 32'(rf_waddr_o), 32'd5);
        check("alu_hazard_lit", haz_seen, 32'd0);

        // lb / lbu at 0x103, ready in the same cycle.
        t = blank(); t.alu = 32'h103; t.we = 1'b1; t.waddr = 5'd7; t.rd = 1'b1;
        t.size = 2'd0; t.sext = 1'b1; t.rdata = 32'h80AB_CDEF; t.lat = 0;
        run_instr(t);
        check("lb_wdata_lit", rf_wdata_o, 32'hFFFF_FF80);
        check("lb_hazard_lit", haz_seen, 32'd0);
        t.sext = 1'b0;
        run_instr(t);
        check("lbu_wdata_lit", rf_wdata_o, 32'h0000_0080);

        // sh at 0x102.
        t = blank(); t.alu = 32'h102; t.we = 1'b1; t.wr = 1'b1; t.size = 2'd1;
        t.sd = 32'h1234_BEEF; t.lat = 0;
        run_instr(t);
        check("sh_be_lit", 32'(first_be), 32'b1100);
        check("sh_wdata_lit", first_wd, 32'hBEEF_BEEF);
        check("sh_we_lit", 32'(rf_we_o), 32'd0);

        // lw with ready after three stall cycles.
        t = blank(); t.alu = 32'h200; t.we = 1'b1; t.waddr = 5'd9; t.rd = 1'b1;
        t.id = 4'd9; t.rdata = 32'hCAFE_F00D; t.lat = 3;
        run_instr(t);
        check("lw_hazard_lit", haz_seen, 32'd3);
        check("lw_wdata_lit", rf_wdata_o, 32'hCAFE_F00D);
        check("lw_id_lit", 32'(instr_id_o), 32'd9);

        // Misaligned lw.
        t = blank(); t.alu = 32'h101; t.we = 1'b1; t.rd = 1'b1;
        run_instr(t);
        check("mis_pulse_lit", 32'(misaligned_o), 32'd1);
        check("mis_we_lit", 32'(rf_we_o), 32'd0);

        // lw that never gets ready.
        t = blank(); t.alu = 32'h300; t.we = 1'b1; t.rd = 1'b1; t.lat = 1000;
        run_instr(t);
        check("to_hazard_lit", haz_seen, 32'd64);
        check("to_buserr_lit", 32'(bus_err_o), 32'd1);
        check("to_we_lit", 32'(rf_we_o), 32'd0);

        // Reset asserted while waiting on memory.
        t = blank(); t.alu = 32'h400; t.we = 1'b1; t.rd = 1'b1; t.id = 4'd3;
        apply(t);
        exp_req = 1'b1; exp_haz = 1'b1; exp_we_mem = 1'b0; exp_store = 1'b0;
        exp_addr = 32'h400; mem_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            exp_mis = 1'b0; exp_berr = 1'b0;
        end
        rsn_i = 1'b0;
        exp_req = 1'b0; exp_haz = 1'b0;
        @(posedge clk);
        #1;
        clear_bundle();
        rsn_i = 1'b1;
        apply(blank());
        check("rst_wdata_lit", rf_wdata_o, 32'd0);
        check("rst_id_lit", 32'(instr_id_o), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            run_instr(rand_instr());
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
